// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a word on a valid/ready handshake
// and emits it MSB first, holding each bit for BIT_CYCLES clocks, followed by
// a one-cycle frame_done pulse.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [CW-1:0]    cyc_q,   cyc_d;

  // State and datapath registers, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          shift_d = data_in;
          bit_d   = BW'(WIDTH - 1);
          cyc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cyc_q == CW'(BIT_CYCLES - 1)) begin
          cyc_d = '0;
          if (bit_q == '0) begin
            state_d = DONE;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            bit_d   = bit_q - BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode; outputs are held inactive while reset is asserted
  always_comb begin
    data_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = IDLE_LEVEL;
    frame_done = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          data_ready = 1'b1;
        end
        SHIFT: begin
          ser_valid = 1'b1;
          ser_out   = shift_q[WIDTH-1];
        end
        DONE: begin
          frame_done = 1'b1;
        end
        default: begin
          data_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializer instances (BIT_CYCLES=2 and 1) driven by
// the same inputs, compared every cycle against a queue-based frame model.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  typedef logic [3:0] ent_q_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         data_valid;
  logic [W-1:0] data_in;
  logic         ready2, sout2, svalid2, done2;
  logic         ready1, sout1, svalid1, done1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  ent_q_t       q2, q1;
  int           hs[$];
  logic [15:0]  cap2;
  logic [7:0]   cap1;

  piso_serializer #(.WIDTH(W), .BIT_CYCLES(2), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready2), .ser_out(sout2), .ser_valid(svalid2), .frame_done(done2)
  );

  piso_serializer #(.WIDTH(W), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_fast (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready1), .ser_out(sout1), .ser_valid(svalid1), .frame_done(done1)
  );

  always #5 clk = ~clk;

  // Compare one observation and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected per-cycle outputs {ready, valid, ser_out, done} for one frame
  function automatic ent_q_t frame(input logic [W-1:0] d, input int bc);
    ent_q_t q;
    for (int i = W - 1; i >= 0; i--)
      for (int k = 0; k < bc; k++) q.push_back({1'b0, 1'b1, d[i], 1'b0});
    q.push_back(4'b0001);
    return q;
  endfunction

  function automatic logic [3:0] expect_now(input ent_q_t q, input logic r);
    if (r) return 4'b0000;
    if (q.size() != 0) return q[0];
    return 4'b1000;
  endfunction

  // One clock: drive inputs, check outputs, then advance model on the edge
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    rst = r; data_valid = v; data_in = d;
    #1;
    check("slow_outputs", 32'({ready2, svalid2, sout2, done2}), 32'(expect_now(q2, r)));
    check("fast_outputs", 32'({ready1, svalid1, sout1, done1}), 32'(expect_now(q1, r)));
    if (!r && v && ready2) hs.push_back(cyc);
    if (svalid2) cap2 = {cap2[14:0], sout2};
    if (svalid1) cap1 = {cap1[6:0], sout1};
    @(posedge clk);
    if (r) begin
      q2.delete(); q1.delete();
    end else begin
      if (q2.size() != 0) void'(q2.pop_front());
      else if (v) q2 = frame(d, 2);
      if (q1.size() != 0) void'(q1.pop_front());
      else if (v) q1 = frame(d, 1);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    @(negedge clk);

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 8'h00);

    // Single A5 frame
    cap2 = '0; cap1 = '0;
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);
    check("a5_stream_slow", 32'(cap2), 32'h0000CC33);
    check("a5_stream_fast", 32'(cap1), 32'h000000A5);

    // Back-to-back with valid held high
    hs.delete();
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);
    check("b2b_count", 32'(hs.size()), 32'd2);
    check("b2b_gap", (hs.size() >= 2) ? 32'(hs[1] - hs[0]) : 32'd0, 32'(W * 2 + 2));

    // Offers ignored while busy, data toggling
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 8'h3C : 8'hC3);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 8'h00);

    // Reset mid-frame, then an 81 frame
    step(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    cap2 = '0; cap1 = '0;
    step(1'b0, 1'b1, 8'h81);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);
    check("x81_stream_slow", 32'(cap2), 32'h0000C003);
    check("x81_stream_fast", 32'(cap1), 32'h00000081);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
           W'($urandom));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
